// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin req/gnt arbiter.
//   arb_state_t : arbiter FSM states
//   pick_t      : result of a rotate-priority search (found flag + index)
//   rr_pick()   : rotate-priority search over up to MAX_REQ request lines
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned MAX_ID_W = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ... wrapping at n.
    // ptr must be < n; bits at or above n are ignored.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                      input int unsigned         n,
                                      input logic [MAX_ID_W-1:0] ptr);
        pick_t       res;
        int unsigned c;
        res = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            c = {28'd0, ptr} + i;
            if (c >= n) c = c - n;
            if ((i < n) && !res.found && req[c[MAX_ID_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = c[MAX_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-priority encoder.
//   req_i   : request vector
//   ptr_i   : index with highest priority
//   found_o : any request set
//   idx_o   : winning index (0 when found_o=0)
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             found_o,
    output logic [ID_W-1:0]  idx_o
);

    pick_t res;

    always_comb begin
        res     = rr_pick(MAX_REQ'(req_i), N_REQ, MAX_ID_W'(ptr_i));
        found_o = res.found;
        idx_o   = ID_W'(res.idx);
    end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter with per-ownership hold limit and one-cycle cool-down.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   req       : per-requester level request
//   gnt       : registered one-hot grant
//   gnt_valid : registered OR of gnt
//   gnt_id    : owner index (0 when idle)
//   hold_cnt  : cycles current owner has held gnt (0 when idle)
//   timeout   : high during the cool-down cycle after a forced release
//
//   state    | meaning
//   IDLE     | no owner, arbitrate from ptr on every edge
//   GRANT    | owner gnt_id holds the resource
//   COOLDOWN | forced release just happened, no grant for one cycle
module rr_req_gnt_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned ID_W     = $clog2(N_REQ),
    parameter int unsigned HOLD_W   = $clog2(MAX_HOLD + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic              gnt_valid,
    output logic [ID_W-1:0]   gnt_id,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              timeout
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic              owner_req;
    logic              limit_hit;
    logic [ID_W-1:0]   ptr_inc;
    logic [ID_W-1:0]   pick_ptr;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;

    assign owner_req = req[gnt_id_q];
    assign limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));
    assign ptr_inc   = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
    // While granted, the only arbitration that can happen is a voluntary
    // handover, which must already use the advanced pointer.
    assign pick_ptr  = (state_q == GRANT) ? ptr_inc : ptr_q;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        hold_d      = '0;
        timeout_d   = 1'b0;

        case (state_q)
            GRANT: begin
                if (owner_req && !limit_hit) begin
                    gnt_d       = gnt_q;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = gnt_id_q;
                    hold_d      = (hold_q == '1) ? hold_q : hold_q + 1'b1;
                end else if (owner_req) begin
                    ptr_d     = ptr_inc;
                    timeout_d = 1'b1;
                    state_d   = COOLDOWN;
                end else begin
                    ptr_d   = ptr_inc;
                    state_d = IDLE;
                    if (pick_found) begin
                        gnt_d       = N_REQ'(1) << pick_idx;
                        gnt_valid_d = 1'b1;
                        gnt_id_d    = pick_idx;
                        hold_d      = HOLD_W'(1);
                        state_d     = GRANT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (pick_found) begin
                    gnt_d       = N_REQ'(1) << pick_idx;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick_idx;
                    hold_d      = HOLD_W'(1);
                    state_d     = GRANT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            hold_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            hold_q      <= hold_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign hold_cnt  = hold_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Self-checking bench for rr_req_gnt_arbiter (N_REQ=4, MAX_HOLD=8).
module tb_rr_req_gnt_arbiter;

    localparam int N     = 4;
    localparam int MAXH  = 8;
    localparam int BOUND = (N - 1) * (MAXH + 1) + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic [3:0]   hold_cnt;
    logic         timeout;

    int checks   = 0;
    int failures = 0;

    // reference model: owner (-1 = none), priority pointer, hold count
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_tout  = 0;
    int wait_c [N];

    always #5 clk = ~clk;

    rr_req_gnt_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .hold_cnt  (hold_cnt),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_tout = 0;
            return;
        end
        m_tout = 0;
        if (m_owner >= 0) begin
            if (r[m_owner] && m_hold < MAXH) begin
                m_hold++;
                return;
            end
            m_ptr = (m_owner + 1) % N;
            if (r[m_owner]) begin
                m_owner = -1; m_hold = 0; m_tout = 1;
                return;
            end
            m_owner = -1; m_hold = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (r[(m_ptr + i) % N]) begin
                m_owner = (m_ptr + i) % N;
                m_hold  = 1;
                break;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] eg;
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("gnt",       32'(gnt),       32'(eg));
        chk("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("gnt_id",    32'(gnt_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("hold_cnt",  32'(hold_cnt),  32'(m_hold));
        chk("timeout",   32'(timeout),   32'(m_tout));
        for (int i = 0; i < N; i++) begin
            if (rs || !r[i] || gnt[i]) wait_c[i] = 0;
            else                       wait_c[i]++;
            if (wait_c[i] > 0) chk("wait_bound", 32'(wait_c[i] <= BOUND), 32'd1);
        end
    endtask

    initial begin
        int      order[$];
        int      tcnt;
        int      gaps;
        logic [N-1:0] r;

        for (int i = 0; i < N; i++) wait_c[i] = 0;

        // reset with all requests high, then idle
        cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b1);
        chk("rst_gnt", 32'(gnt), 32'd0);
        repeat (3) cycle(4'b0000, 1'b0);
        chk("idle_gnt", 32'(gnt), 32'd0);

        // single request latency and release
        cycle(4'b0100, 1'b0);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_id",  32'(gnt_id), 32'd2);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        chk("single_hold3", 32'(hold_cnt), 32'd3);
        cycle(4'b0000, 1'b0);
        chk("single_rel", 32'(gnt), 32'd0);
        cycle(4'b0101, 1'b0);
        chk("scan_from3", 32'(gnt_id), 32'd0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // back-to-back round robin, each owner holds two cycles
        cycle(4'b0000, 1'b1);
        gaps = 0;
        for (int k = 0; k < 10; k++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_hold == 2) r[m_owner] = 1'b0;
            cycle(r, 1'b0);
            if (!gnt_valid) gaps++;
            if (gnt_valid && hold_cnt == 4'd1) order.push_back(int'(gnt_id));
        end
        chk("b2b_gaps",  32'(gaps), 32'd0);
        chk("b2b_count", 32'(order.size()), 32'd5);
        if (order.size() == 5) begin
            chk("b2b_o0", 32'(order[0]), 32'd0);
            chk("b2b_o1", 32'(order[1]), 32'd1);
            chk("b2b_o2", 32'(order[2]), 32'd2);
            chk("b2b_o3", 32'(order[3]), 32'd3);
            chk("b2b_o4", 32'(order[4]), 32'd0);
        end

        // timeout with a single persistent requester
        cycle(4'b0000, 1'b1);
        tcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(4'b0001, 1'b0);
            if (timeout) tcnt++;
            if (k == 8)  chk("to_hold8", 32'(hold_cnt), 32'd8);
            if (k == 9)  chk("to_pulse", {30'd0, gnt_valid, timeout}, 32'd1);
            if (k == 10) chk("to_regrant", {gnt, hold_cnt}, {24'd0, 4'b0001, 4'd1});
        end
        chk("to_count", 32'(tcnt), 32'd2);

        // timeout fairness between two persistent requesters
        cycle(4'b0000, 1'b1);
        tcnt = 0;
        order.delete();
        for (int k = 1; k <= 27; k++) begin
            cycle(4'b0011, 1'b0);
            if (timeout) tcnt++;
            if (gnt_valid && hold_cnt == 4'd1) order.push_back(int'(gnt_id));
        end
        chk("fair_tcount", 32'(tcnt), 32'd3);
        chk("fair_owners", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            chk("fair_o0", 32'(order[0]), 32'd0);
            chk("fair_o1", 32'(order[1]), 32'd1);
            chk("fair_o2", 32'(order[2]), 32'd0);
        end

        // reset in the middle of a grant
        cycle(4'b0000, 1'b1);
        repeat (5) cycle(4'b0010, 1'b0);
        chk("mid_hold5", 32'(hold_cnt), 32'd5);
        cycle(4'b0010, 1'b1);
        chk("mid_rst", {gnt, gnt_valid, hold_cnt, timeout}, 32'd0);
        cycle(4'b0010, 1'b0);
        chk("mid_regrant", {gnt, hold_cnt}, {24'd0, 4'b0010, 4'd1});
        cycle(4'b0000, 1'b0);
        cycle(4'b1010, 1'b0);
        chk("mid_ptr", 32'(gnt_id), 32'd3);

        // randomized traffic against the model
        cycle(4'b0000, 1'b1);
        r = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            if ($urandom_range(15) == 0) r = 4'b1111;
            cycle(r, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_req_gnt_arbiter.md
Name: rr_req_gnt_arbiter

Overview:
- Round-robin arbiter that shares one req/gnt-protocol resource among N_REQ requesters.
- Each requester drives its own req line. The arbiter returns a one-hot registered gnt.
- A grant is held while the owner keeps req high, up to a MAX_HOLD-cycle limit. When the limit is reached, the grant is forcibly revoked and the arbiter spends one cool-down cycle with no grant.
- Sits between the requesting masters and the shared resource; gnt_id drives the resource's input mux.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 = unlimited.
- ID_W, $clog2(N_REQ), width of gnt_id.
- HOLD_W, $clog2(MAX_HOLD+2), width of hold_cnt.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request, level-sensitive.
- gnt  output  N_REQ  one-hot grant, registered; all-zero when no owner.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  ID_W  index of current owner; 0 when gnt_valid=0.
- hold_cnt  output  HOLD_W  cycles the current owner has held gnt (1 on first grant cycle); 0 when idle.
- timeout  output  1  one-cycle pulse in the cycle after a forced release.

Behaviour:

Reset (rst sampled high at posedge):
- gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, timeout=0.
- Priority pointer ptr=0, state=IDLE.
- Reset overrides every other event, including during a grant. There is no partial grant after reset is released.

State IDLE:
- If any req bit is high at edge k, select the first requester with req=1, scanning ptr, ptr+1, …, wrapping mod N_REQ.
- After edge k: gnt[sel]=1, gnt_id=sel, hold_cnt=1, state=GRANT. Latency is 1 cycle from req to gnt.

State GRANT, owner o:
- Hold: req[o]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD) → keep gnt. hold_cnt increments, saturating at all-ones when MAX_HOLD=0.
- Voluntary release: req[o]=0 at edge k → ptr=(o+1) mod N_REQ.
  - Re-arbitrate in the same edge over the other requesters using the new ptr.
  - If a winner w exists: gnt[w]=1 and hold_cnt=1 after edge k (back-to-back handover, no idle cycle).
  - Otherwise: gnt=0 and state=IDLE.
- Forced release: req[o]=1 and hold_cnt==MAX_HOLD (MAX_HOLD>0) at edge k.
  - After edge k: gnt=0, hold_cnt=0, timeout=1, ptr=(o+1) mod N_REQ, state=COOLDOWN.

State COOLDOWN:
- Exactly one cycle with no grant; timeout is high during it.
- On the next edge, arbitrate as in IDLE using the updated ptr (timeout returns to 0).
- If o is the only requester, o is re-granted after the cool-down.

Invariants:
- gnt is always one-hot or zero.
- gnt_id == index of the set gnt bit.
- No requester waits more than (N_REQ-1)*(MAX_HOLD+1)+1 cycles while holding req high (MAX_HOLD>0).

Other rules:
- req changes on non-owner lines never affect the current grant.
- Arithmetic: ptr wraps mod N_REQ, which works for non-power-of-two N_REQ. hold_cnt compare is unsigned.

Decomposition:
- Package rr_arb_pkg:
  - typedef enum {IDLE, GRANT, COOLDOWN} arb_state_t
  - function rr_pick(req, ptr): returns found flag + index.
- Sub-module rr_priority_pick: combinational rotate-priority encoder taking req[N_REQ] and ptr[ID_W], producing found and idx[ID_W].
- The top module holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, req=4'b1111 → gnt=0, gnt_id=0, hold_cnt=0 throughout. After rst drops with req=4'b0000 → outputs stay 0.
- Single request latency: req=4'b0100 set at edge k → gnt=4'b0100, gnt_id=2, hold_cnt=1 after edge k. Drop req at edge k+3 → gnt=0 after k+3, next winner scan starts at 3.
- Back-to-back round robin: req=4'b1111 held, each owner drops req for one cycle after holding 2 cycles → grant order 0,1,2,3,0 with no gnt=0 cycle between owners.
- Timeout, MAX_HOLD=8: req=4'b0001 held constantly → gnt[0] high 8 cycles (hold_cnt 1..8), then gnt=0 and timeout=1 for one cycle, then gnt[0] re-granted with hold_cnt=1.
- Timeout fairness: req=4'b0011 held constantly → req0 gets 8 cycles, then 1 cooldown, then req1 gets 8 cycles, then 1 cooldown, then req0 again; timeout pulses every 9 cycles.
- Reset mid-grant: gnt=4'b0010 at hold_cnt=5, rst=1 for 1 cycle → all outputs 0 after that edge. After release with req=4'b0010 → re-granted with hold_cnt=1 and ptr=0 ordering.
